// File: rtl/dram_pkg.sv
// ----------------------------------------------------------------------------
// dram_pkg
// Shared definitions for the SDRAM command arbiter: SDRAM timing constants
// used by the command engine, the arbiter FSM state encoding and the
// command-owner encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package dram_pkg;

  // SDRAM timing in clk_100 cycles (consumed by the command engine).
  localparam int T_RP  = 2;
  localparam int T_RC  = 7;
  localparam int T_RCD = 2;
  localparam int T_CAS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_A   = 2'd0,
    OWN_B   = 2'd1,
    OWN_REF = 2'd2
  } owner_e;

  // The client that is not 'o'; only meaningful for OWN_A / OWN_B.
  function automatic owner_e other_client(input owner_e o);
    return (o == OWN_A) ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// ----------------------------------------------------------------------------
// dram_refresh_timer
// Free-running refresh interval counter plus a saturating count of refreshes
// still owed to the SDRAM.
// Ports:
//   clk_100    in   clock, rising edge
//   rst_n      in   synchronous reset, active low
//   tick_en    in   counter advances while high
//   ref_taken  in   a refresh command was accepted this cycle
//   ref_pend   out  number of refreshes owed (saturates at MAX_PEND_REF)
// ----------------------------------------------------------------------------
module dram_refresh_timer #(
  parameter int REFRESH_CYCLES = 780,
  parameter int MAX_PEND_REF   = 8,
  parameter int PEND_W         = $clog2(MAX_PEND_REF + 1)
) (
  input  logic              clk_100,
  input  logic              rst_n,
  input  logic              tick_en,
  input  logic              ref_taken,
  output logic [PEND_W-1:0] ref_pend
);

  localparam int TIMER_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] RELOAD   = TIMER_W'(REFRESH_CYCLES - 1);
  localparam logic [PEND_W-1:0]  PEND_MAX = PEND_W'(MAX_PEND_REF);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [PEND_W-1:0]  ref_pend_q, ref_pend_d;
  logic               tick;

  always_comb begin
    timer_d = timer_q;
    tick    = 1'b0;
    if (tick_en) begin
      if (timer_q == '0) begin
        timer_d = RELOAD;
        tick    = 1'b1;
      end else begin
        timer_d = timer_q - TIMER_W'(1);
      end
    end
  end

  // A tick coinciding with an accepted refresh leaves the count unchanged.
  always_comb begin
    ref_pend_d = ref_pend_q;
    if (tick && !ref_taken) begin
      if (ref_pend_q != PEND_MAX) ref_pend_d = ref_pend_q + PEND_W'(1);
    end else if (ref_taken && !tick) begin
      if (ref_pend_q != '0) ref_pend_d = ref_pend_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      timer_q    <= RELOAD;
      ref_pend_q <= '0;
    end else begin
      timer_q    <= timer_d;
      ref_pend_q <= ref_pend_d;
    end
  end

  assign ref_pend = ref_pend_q;

endmodule

// File: rtl/dram_arbiter.sv
// ----------------------------------------------------------------------------
// dram_arbiter
// Shares one SDRAM command engine between clients A, B and periodic refresh.
// Refresh has absolute priority; A and B alternate round-robin. No grant is
// made until the engine reports init done. One command in flight at a time:
// IDLE (select) -> ISSUE (offer until ready) -> BUSY (wait cmd_done) -> IDLE.
// Ports:
//   clk_100, rst_n (sync, active low), init_done
//   a_/b_ req, we, ba[1:0], row[ROW_W-1:0]   client requests (held until done)
//   a_/b_ gnt, done                          grant level / completion pulse
//   cmd_valid/cmd_ready handshake, cmd_refresh, cmd_we, cmd_ba, cmd_row
//   cmd_done                                 engine completion pulse
// Optional build macro ARB_STATS_EN adds stat_a, stat_b, stat_ref (16-bit
// accepted-command counters, wrapping) and sticky stat_ref_sat.
// ----------------------------------------------------------------------------
module dram_arbiter
  import dram_pkg::*;
#(
  parameter int REFRESH_CYCLES = 780,
  parameter int MAX_PEND_REF   = 8,
  parameter int ROW_W          = 13
) (
  input  logic             clk_100,
  input  logic             rst_n,
  input  logic             init_done,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [1:0]       a_ba,
  input  logic [ROW_W-1:0] a_row,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [1:0]       b_ba,
  input  logic [ROW_W-1:0] b_row,
  output logic             a_gnt,
  output logic             b_gnt,
  output logic             a_done,
  output logic             b_done,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_refresh,
  output logic             cmd_we,
  output logic [1:0]       cmd_ba,
  output logic [ROW_W-1:0] cmd_row,
  input  logic             cmd_done
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]      stat_a,
  output logic [15:0]      stat_b,
  output logic [15:0]      stat_ref,
  output logic             stat_ref_sat
`endif
);

  localparam int PEND_W = $clog2(MAX_PEND_REF + 1);

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  owner_e           rr_ptr_q, rr_ptr_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             cmd_refresh_q, cmd_refresh_d;
  logic             cmd_we_q, cmd_we_d;
  logic [1:0]       cmd_ba_q, cmd_ba_d;
  logic [ROW_W-1:0] cmd_row_q, cmd_row_d;
  logic             a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic             a_done_q, a_done_d, b_done_q, b_done_d;

  logic [PEND_W-1:0] ref_pend;
  logic              cmd_accept, ref_taken;
  logic              sel_any, rr_req, oth_req;
  owner_e            sel_owner;

  assign cmd_accept = (state_q == ISSUE) && cmd_ready;
  assign ref_taken  = cmd_accept && (owner_q == OWN_REF);

  dram_refresh_timer #(
    .REFRESH_CYCLES (REFRESH_CYCLES),
    .MAX_PEND_REF   (MAX_PEND_REF),
    .PEND_W         (PEND_W)
  ) u_ref_timer (
    .clk_100   (clk_100),
    .rst_n     (rst_n),
    .tick_en   (1'b1),
    .ref_taken (ref_taken),
    .ref_pend  (ref_pend)
  );

  // Selection made in IDLE. Any owed refresh wins, so a saturated ref_pend
  // automatically forces refresh ahead of both clients.
  always_comb begin
    rr_req    = (rr_ptr_q == OWN_A) ? a_req : b_req;
    oth_req   = (rr_ptr_q == OWN_A) ? b_req : a_req;
    sel_any   = 1'b0;
    sel_owner = OWN_REF;
    if (init_done) begin
      if (ref_pend != '0) begin
        sel_any   = 1'b1;
        sel_owner = OWN_REF;
      end else if (rr_req) begin
        sel_any   = 1'b1;
        sel_owner = rr_ptr_q;
      end else if (oth_req) begin
        sel_any   = 1'b1;
        sel_owner = other_client(rr_ptr_q);
      end
    end
  end

  // State register
  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= OWN_A;
      rr_ptr_q      <= OWN_A;
      cmd_valid_q   <= 1'b0;
      cmd_refresh_q <= 1'b0;
      cmd_we_q      <= 1'b0;
      cmd_ba_q      <= '0;
      cmd_row_q     <= '0;
      a_gnt_q       <= 1'b0;
      b_gnt_q       <= 1'b0;
      a_done_q      <= 1'b0;
      b_done_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_refresh_q <= cmd_refresh_d;
      cmd_we_q      <= cmd_we_d;
      cmd_ba_q      <= cmd_ba_d;
      cmd_row_q     <= cmd_row_d;
      a_gnt_q       <= a_gnt_d;
      b_gnt_q       <= b_gnt_d;
      a_done_q      <= a_done_d;
      b_done_q      <= b_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_any)   state_d = ISSUE;
      ISSUE:   if (cmd_ready) state_d = BUSY;
      BUSY:    if (cmd_done)  state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_refresh_d = cmd_refresh_q;
    cmd_we_d      = cmd_we_q;
    cmd_ba_d      = cmd_ba_q;
    cmd_row_d     = cmd_row_q;
    a_gnt_d       = a_gnt_q;
    b_gnt_d       = b_gnt_q;
    a_done_d      = 1'b0;
    b_done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        // Grants stay up through the done cycle (which is an IDLE cycle)
        // and fall here unless the same client is re-selected.
        a_gnt_d = 1'b0;
        b_gnt_d = 1'b0;
        if (sel_any) begin
          owner_d       = sel_owner;
          cmd_valid_d   = 1'b1;
          cmd_refresh_d = (sel_owner == OWN_REF);
          a_gnt_d       = (sel_owner == OWN_A);
          b_gnt_d       = (sel_owner == OWN_B);
          cmd_we_d      = 1'b0;
          cmd_ba_d      = '0;
          cmd_row_d     = '0;
          if (sel_owner == OWN_A) begin
            cmd_we_d  = a_we;
            cmd_ba_d  = a_ba;
            cmd_row_d = a_row;
          end else if (sel_owner == OWN_B) begin
            cmd_we_d  = b_we;
            cmd_ba_d  = b_ba;
            cmd_row_d = b_row;
          end
        end
      end
      ISSUE: begin
        if (cmd_ready) cmd_valid_d = 1'b0;
      end
      BUSY: begin
        if (cmd_done) begin
          cmd_refresh_d = 1'b0;
          if (owner_q == OWN_A) begin
            a_done_d = 1'b1;
            rr_ptr_d = OWN_B;
          end else if (owner_q == OWN_B) begin
            b_done_d = 1'b1;
            rr_ptr_d = OWN_A;
          end
        end
      end
      default: ;
    endcase
  end

  assign a_gnt       = a_gnt_q;
  assign b_gnt       = b_gnt_q;
  assign a_done      = a_done_q;
  assign b_done      = b_done_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_refresh = cmd_refresh_q;
  assign cmd_we      = cmd_we_q;
  assign cmd_ba      = cmd_ba_q;
  assign cmd_row     = cmd_row_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_a_q, stat_a_d, stat_b_q, stat_b_d, stat_ref_q, stat_ref_d;
  logic        stat_ref_sat_q, stat_ref_sat_d;

  always_comb begin
    stat_a_d       = stat_a_q;
    stat_b_d       = stat_b_q;
    stat_ref_d     = stat_ref_q;
    stat_ref_sat_d = stat_ref_sat_q | (ref_pend == PEND_W'(MAX_PEND_REF));
    if (cmd_accept) begin
      case (owner_q)
        OWN_A:   stat_a_d   = stat_a_q + 16'd1;
        OWN_B:   stat_b_d   = stat_b_q + 16'd1;
        default: stat_ref_d = stat_ref_q + 16'd1;
      endcase
    end
  end

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      stat_a_q       <= '0;
      stat_b_q       <= '0;
      stat_ref_q     <= '0;
      stat_ref_sat_q <= 1'b0;
    end else begin
      stat_a_q       <= stat_a_d;
      stat_b_q       <= stat_b_d;
      stat_ref_q     <= stat_ref_d;
      stat_ref_sat_q <= stat_ref_sat_d;
    end
  end

  assign stat_a       = stat_a_q;
  assign stat_b       = stat_b_q;
  assign stat_ref     = stat_ref_q;
  assign stat_ref_sat = stat_ref_sat_q;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dram_arbiter
// Directed bench for dram_arbiter with a small engine model that accepts
// commands on cmd_ready and pulses cmd_done eng_delay cycles later. A monitor
// appends one letter per accepted command (R/A/B) to log_s.
// Stats checks are compiled only when ARB_STATS_EN is defined.
// ----------------------------------------------------------------------------
module tb_dram_arbiter;

  localparam int ROW_W = 13;

  logic             clk_100 = 1'b0;
  logic             rst_n, init_done;
  logic             a_req, a_we, b_req, b_we;
  logic [1:0]       a_ba, b_ba;
  logic [ROW_W-1:0] a_row, b_row;
  logic             a_gnt, b_gnt, a_done, b_done;
  logic             cmd_valid, cmd_ready, cmd_refresh, cmd_we, cmd_done;
  logic [1:0]       cmd_ba;
  logic [ROW_W-1:0] cmd_row;
`ifdef ARB_STATS_EN
  logic [15:0]      stat_a, stat_b, stat_ref;
  logic             stat_ref_sat;
`endif

  int    errors = 0;
  int    checks = 0;
  int    eng_delay = 5;
  string log_s = "";
  bit    done_double = 1'b0;

  always #5 clk_100 = ~clk_100;

  dram_arbiter #(.REFRESH_CYCLES(780), .MAX_PEND_REF(8), .ROW_W(ROW_W)) u_dut (
    .clk_100(clk_100), .rst_n(rst_n), .init_done(init_done),
    .a_req(a_req), .a_we(a_we), .a_ba(a_ba), .a_row(a_row),
    .b_req(b_req), .b_we(b_we), .b_ba(b_ba), .b_row(b_row),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_done(a_done), .b_done(b_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_refresh(cmd_refresh),
    .cmd_we(cmd_we), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_done(cmd_done)
`ifdef ARB_STATS_EN
    ,
    .stat_a(stat_a), .stat_b(stat_b), .stat_ref(stat_ref), .stat_ref_sat(stat_ref_sat)
`endif
  );

  // Engine model: looks at the handshake that the next edge will take.
  initial begin : engine
    bit eng_pending;
    int eng_cnt;
    eng_pending = 1'b0;
    eng_cnt = 0;
    cmd_done = 1'b0;
    forever begin
      @(posedge clk_100); #3;
      cmd_done = 1'b0;
      if (!rst_n) begin
        eng_pending = 1'b0;
      end else if (eng_pending) begin
        if (eng_cnt <= 1) begin
          cmd_done = 1'b1;
          eng_pending = 1'b0;
        end else begin
          eng_cnt--;
        end
      end else if (cmd_valid && cmd_ready) begin
        eng_pending = 1'b1;
        eng_cnt = eng_delay;
      end
    end
  end

  // Monitor: one line per accepted command, done-pulse width watch.
  initial begin : monitor
    bit pa, pb;
    pa = 1'b0;
    pb = 1'b0;
    forever begin
      @(posedge clk_100); #4;
      if (rst_n && cmd_valid && cmd_ready) begin
        if (cmd_refresh) log_s = {log_s, "R"};
        else if (a_gnt)  log_s = {log_s, "A"};
        else if (b_gnt)  log_s = {log_s, "B"};
        else             log_s = {log_s, "?"};
        $display("[%0t] accept cmd refresh=%0b we=%0b ba=%0d row=%0h a_gnt=%0b b_gnt=%0b",
                 $time, cmd_refresh, cmd_we, cmd_ba, cmd_row, a_gnt, b_gnt);
      end
      if ((a_done && pa) || (b_done && pb)) done_double = 1'b1;
      pa = a_done;
      pb = b_done;
    end
  end

  task automatic tick();
    @(posedge clk_100); #2;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %0b want 0", cmd_valid); end
    checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got a=%0b b=%0b want 0 0", a_gnt, b_gnt); end
    checks++; if (a_done !== 1'b0 || b_done !== 1'b0) begin errors++; $display("FAIL reset_done: got a=%0b b=%0b want 0 0", a_done, b_done); end
    checks++; if (cmd_refresh !== 1'b0) begin errors++; $display("FAIL reset_cmd_refresh: got %0b want 0", cmd_refresh); end
    checks++; if (u_dut.u_ref_timer.timer_q !== 10'd779) begin errors++; $display("FAIL reset_timer: got %0d want 779", u_dut.u_ref_timer.timer_q); end
    checks++; if (u_dut.ref_pend !== 4'd0) begin errors++; $display("FAIL reset_pend: got %0d want 0", u_dut.ref_pend); end
    rst_n = 1'b1;
    $display("test_reset complete");
  endtask

  task automatic test_init_hold();
    bit seen;
    seen = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_ba = 2'd1; a_row = 13'h0123;
    repeat (2000) begin
      tick();
      if (cmd_valid || a_gnt || b_gnt) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL init_hold_no_grant: got activity=%0b want 0", seen); end
    checks++; if (u_dut.ref_pend !== 4'd2) begin errors++; $display("FAIL init_hold_pend: got %0d want 2", u_dut.ref_pend); end
    $display("test_init_hold complete");
  endtask

  task automatic test_refresh_first();
    int dones, dones_at_gnt;
    bit got;
    dones = 0; dones_at_gnt = -1; got = 1'b0;
    log_s = "";
    init_done = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      if (a_gnt && dones_at_gnt < 0) dones_at_gnt = dones;
      if (cmd_done) dones++;
      if (a_done) begin got = 1'b1; a_req = 1'b0; end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL refresh_first_timeout: got a_done=%0b want 1", got); end
    checks++; if (log_s != "RRA") begin errors++; $display("FAIL refresh_first_order: got %s want RRA", log_s); end
    checks++; if (dones_at_gnt !== 2) begin errors++; $display("FAIL refresh_first_gnt_after: got %0d dones want 2", dones_at_gnt); end
    $display("test_refresh_first complete");
  endtask

  task automatic test_fields();
    bit stable, got;
    stable = 1'b1; got = 1'b0;
    log_s = "";
    cmd_ready = 1'b0;
    b_we = 1'b1; b_ba = 2'd2; b_row = 13'h1ABC;
    b_req = 1'b1;
    tick();
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL fields_latency: got cmd_valid=%0b want 1", cmd_valid); end
    checks++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin errors++; $display("FAIL fields_gnt: got a=%0b b=%0b want 0 1", a_gnt, b_gnt); end
    checks++; if (cmd_refresh !== 1'b0) begin errors++; $display("FAIL fields_refresh: got %0b want 0", cmd_refresh); end
    checks++; if (cmd_we !== 1'b1) begin errors++; $display("FAIL fields_we: got %0b want 1", cmd_we); end
    checks++; if (cmd_ba !== 2'd2) begin errors++; $display("FAIL fields_ba: got %0d want 2", cmd_ba); end
    checks++; if (cmd_row !== 13'h1ABC) begin errors++; $display("FAIL fields_row: got %0h want 1abc", cmd_row); end
    repeat (10) begin
      tick();
      if (!(cmd_valid === 1'b1 && cmd_we === 1'b1 && cmd_ba === 2'd2 && cmd_row === 13'h1ABC && b_gnt === 1'b1))
        stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL fields_stable: got stable=%0b want 1", stable); end
    cmd_ready = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      if (b_done) begin got = 1'b1; b_req = 1'b0; end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL fields_done_timeout: got b_done=%0b want 1", got); end
    checks++; if (log_s != "B") begin errors++; $display("FAIL fields_order: got %s want B", log_s); end
    $display("test_fields complete");
  endtask

  task automatic test_alternate();
    int na, nb;
    na = 0; nb = 0;
    log_s = "";
    done_double = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    for (int i = 0; i < 400 && (na + nb) < 4; i++) begin
      tick();
      if (a_done) na++;
      if (b_done) nb++;
      if ((na + nb) == 4) begin a_req = 1'b0; b_req = 1'b0; end
    end
    a_req = 1'b0; b_req = 1'b0;
    checks++; if (log_s != "ABAB") begin errors++; $display("FAIL alternate_order: got %s want ABAB", log_s); end
    checks++; if (na !== 2 || nb !== 2) begin errors++; $display("FAIL alternate_dones: got a=%0d b=%0d want 2 2", na, nb); end
    checks++; if (done_double !== 1'b0) begin errors++; $display("FAIL alternate_pulse_width: got wide=%0b want 0", done_double); end
    $display("test_alternate complete");
  endtask

  task automatic test_refresh_collision();
    bit found;
    int dones;
    found = 1'b0; dones = 0;
    log_s = "";
    cmd_ready = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick();
      if (cmd_valid && cmd_refresh) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL collision_refresh_timeout: got found=%0b want 1", found); end
    checks++; if (u_dut.ref_pend !== 4'd1) begin errors++; $display("FAIL collision_pend_before: got %0d want 1", u_dut.ref_pend); end
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (u_dut.u_ref_timer.timer_q == 10'd0) found = 1'b1;
      else tick();
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL collision_timer_timeout: got found=%0b want 1", found); end
    cmd_ready = 1'b1;
    tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL collision_accepted: got cmd_valid=%0b want 0", cmd_valid); end
    checks++; if (u_dut.ref_pend !== 4'd1) begin errors++; $display("FAIL collision_pend_unchanged: got %0d want 1", u_dut.ref_pend); end
    checks++; if (u_dut.u_ref_timer.timer_q !== 10'd779) begin errors++; $display("FAIL collision_timer_reload: got %0d want 779", u_dut.u_ref_timer.timer_q); end
    for (int i = 0; i < 100 && dones < 2; i++) begin
      tick();
      if (cmd_done) dones++;
    end
    checks++; if (log_s != "RR") begin errors++; $display("FAIL collision_order: got %s want RR", log_s); end
    checks++; if (u_dut.ref_pend !== 4'd0) begin errors++; $display("FAIL collision_pend_after: got %0d want 0", u_dut.ref_pend); end
    $display("test_refresh_collision complete");
  endtask

  task automatic test_refresh_preempt();
    bit got;
    got = 1'b0;
    log_s = "";
    eng_delay = 1000;
    a_req = 1'b1; b_req = 1'b1;
    repeat (3) tick();
    eng_delay = 5;
    for (int i = 0; i < 1500 && !got; i++) begin
      tick();
      if (a_done) a_req = 1'b0;
      if (b_done) begin got = 1'b1; b_req = 1'b0; end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL preempt_timeout: got b_done=%0b want 1", got); end
    checks++; if (log_s != "ARB") begin errors++; $display("FAIL preempt_order: got %s want ARB", log_s); end
    $display("test_refresh_preempt complete");
  endtask

  task automatic test_reset_in_issue();
    cmd_ready = 1'b0;
    a_req = 1'b1;
    for (int i = 0; i < 20 && !cmd_valid; i++) tick();
    checks++; if (cmd_valid !== 1'b1 || a_gnt !== 1'b1) begin errors++; $display("FAIL rst_issue_setup: got valid=%0b a_gnt=%0b want 1 1", cmd_valid, a_gnt); end
    rst_n = 1'b0;
    tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_issue_valid: got %0b want 0", cmd_valid); end
    checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin errors++; $display("FAIL rst_issue_gnt: got a=%0b b=%0b want 0 0", a_gnt, b_gnt); end
    checks++; if (u_dut.u_ref_timer.timer_q !== 10'd779) begin errors++; $display("FAIL rst_issue_timer: got %0d want 779", u_dut.u_ref_timer.timer_q); end
    a_req = 1'b0;
    cmd_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    $display("test_reset_in_issue complete");
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    bit got;
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      a_req = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
        tick();
        if (a_done) begin got = 1'b1; a_req = 1'b0; end
      end
      tick();
    end
    checks++; if (stat_a !== 16'd3) begin errors++; $display("FAIL stats_a: got %0d want 3", stat_a); end
    checks++; if (stat_b !== 16'd0 || stat_ref !== 16'd0) begin errors++; $display("FAIL stats_other: got b=%0d ref=%0d want 0 0", stat_b, stat_ref); end
    u_dut.stat_a_q = 16'hFFFF;
    got = 1'b0;
    a_req = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      if (a_done) begin got = 1'b1; a_req = 1'b0; end
    end
    checks++; if (stat_a !== 16'd0) begin errors++; $display("FAIL stats_wrap: got %0h want 0", stat_a); end
    $display("test_stats complete");
  endtask
`endif

  initial begin
    rst_n = 1'b0; init_done = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_ba = 2'd0; a_row = '0;
    b_req = 1'b0; b_we = 1'b0; b_ba = 2'd0; b_row = '0;
    cmd_ready = 1'b1;
    test_reset();
    test_init_hold();
    test_refresh_first();
    test_fields();
    test_alternate();
    test_refresh_collision();
    test_refresh_preempt();
    test_reset_in_issue();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
